// File: rtl/bip_control_unit.sv
// BIP control unit: owns the PC, sequences fetch/execute over a synchronous-read
// program memory and decodes each instruction into datapath/data-RAM controls.
module bip_control_unit #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
    parameter int NB_SELECTOR_A  = 2,
    parameter int NB_CYCLES      = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDR-1:0]        o_prog_addr,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [NB_SELECTOR_A-1:0]  o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_enb_acc,
    output logic                      o_operation,
    output logic                      o_wr_ram,
    output logic                      o_rd_ram,
    output logic                      o_halt,
    output logic [NB_CYCLES-1:0]      o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    localparam logic [NB_SELECTOR_A-1:0] SEL_A_RAM     = NB_SELECTOR_A'(0);
    localparam logic [NB_SELECTOR_A-1:0] SEL_A_OPERAND = NB_SELECTOR_A'(1);
    localparam logic [NB_SELECTOR_A-1:0] SEL_A_ALU     = NB_SELECTOR_A'(2);

    localparam logic [NB_ADDR-1:0]   PC_ONE  = NB_ADDR'(1);
    localparam logic [NB_CYCLES-1:0] CYC_ONE = NB_CYCLES'(1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [NB_ADDR-1:0]        r_pc;
    logic [NB_CYCLES-1:0]      r_cycle_count;
    logic                      r_halt;
    logic                      w_pc_inc;
    logic                      w_counting;
    logic [NB_OPCODE-1:0]      w_opcode;
    logic [NB_OPERAND-1:0]     w_operand;

    assign w_opcode   = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign w_operand  = i_instruction[NB_OPERAND-1:0];
    assign w_counting = (r_state == ST_FETCH) || (r_state == ST_EXEC);

    assign o_prog_addr   = r_pc;
    assign o_halt        = r_halt;
    assign o_cycle_count = r_cycle_count;

    // Decode is purely combinational and gated by EXEC, so an async reset drops strobes at once.
    always_comb begin
        w_next_state = r_state;
        w_pc_inc     = 1'b0;
        o_operand    = '0;
        o_sel_a      = SEL_A_RAM;
        o_sel_b      = 1'b0;
        o_enb_acc    = 1'b0;
        o_operation  = 1'b0;
        o_wr_ram     = 1'b0;
        o_rd_ram     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                o_operand = w_operand;
                case (w_opcode)
                    OP_STO: begin
                        o_wr_ram = 1'b1;
                    end
                    OP_LD: begin
                        o_rd_ram  = 1'b1;
                        o_sel_a   = SEL_A_RAM;
                        o_enb_acc = 1'b1;
                    end
                    OP_LDI: begin
                        o_sel_a   = SEL_A_OPERAND;
                        o_enb_acc = 1'b1;
                    end
                    OP_ADD: begin
                        o_rd_ram  = 1'b1;
                        o_sel_a   = SEL_A_ALU;
                        o_enb_acc = 1'b1;
                    end
                    OP_ADDI: begin
                        o_sel_a   = SEL_A_ALU;
                        o_sel_b   = 1'b1;
                        o_enb_acc = 1'b1;
                    end
                    OP_SUB: begin
                        o_rd_ram    = 1'b1;
                        o_sel_a     = SEL_A_ALU;
                        o_operation = 1'b1;
                        o_enb_acc   = 1'b1;
                    end
                    OP_SUBI: begin
                        o_sel_a     = SEL_A_ALU;
                        o_sel_b     = 1'b1;
                        o_operation = 1'b1;
                        o_enb_acc   = 1'b1;
                    end
                    default: begin
                    end
                endcase

                if (w_opcode == OP_HLT) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                    w_pc_inc     = 1'b1;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_cycle_count <= '0;
            r_halt        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_halt  <= (w_next_state == ST_HALT);
            if (w_pc_inc) begin
                r_pc <= r_pc + PC_ONE;
            end
            if (w_counting) begin
                r_cycle_count <= r_cycle_count + CYC_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: instruction-level reference model
// driven by directed and randomized programs in a behavioural program memory.
module tb_bip_control_unit;

    localparam int NB_INSTRUCTION = 16;
    localparam int NB_ADDR        = 11;
    localparam int NB_OPCODE      = 5;
    localparam int NB_OPERAND     = 11;
    localparam int NB_CYCLES      = 32;
    localparam int MEM_DEPTH      = 2048;

    logic                      clk;
    logic                      i_reset;
    logic                      i_start;
    logic [NB_INSTRUCTION-1:0] r_instr;
    logic [NB_ADDR-1:0]        o_prog_addr;
    logic [NB_OPERAND-1:0]     o_operand;
    logic [1:0]                o_sel_a;
    logic                      o_sel_b;
    logic                      o_enb_acc;
    logic                      o_operation;
    logic                      o_wr_ram;
    logic                      o_rd_ram;
    logic                      o_halt;
    logic [NB_CYCLES-1:0]      o_cycle_count;

    logic [NB_INSTRUCTION-1:0] mem [0:MEM_DEPTH-1];

    int tests_run    = 0;
    int tests_failed = 0;

    bip_control_unit #(
        .NB_INSTRUCTION(NB_INSTRUCTION),
        .NB_ADDR       (NB_ADDR),
        .NB_OPCODE     (NB_OPCODE),
        .NB_CYCLES     (NB_CYCLES)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_instruction(r_instr),
        .o_prog_addr  (o_prog_addr),
        .o_operand    (o_operand),
        .o_sel_a      (o_sel_a),
        .o_sel_b      (o_sel_b),
        .o_enb_acc    (o_enb_acc),
        .o_operation  (o_operation),
        .o_wr_ram     (o_wr_ram),
        .o_rd_ram     (o_rd_ram),
        .o_halt       (o_halt),
        .o_cycle_count(o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memory: data valid one cycle after the address.
    always @(posedge clk) r_instr <= mem[o_prog_addr];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] strobes();
        return {o_sel_a, o_sel_b, o_enb_acc, o_operation, o_wr_ram, o_rd_ram, o_operand};
    endfunction

    // Expected {sel_a, sel_b, enb_acc, operation, wr_ram, rd_ram} per opcode.
    function automatic logic [6:0] ref_ctrl(input logic [4:0] op);
        case (op)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_1_0_0_1;
            5'd3:    return 7'b01_0_1_0_0_0;
            5'd4:    return 7'b10_0_1_0_0_1;
            5'd5:    return 7'b10_1_1_0_0_0;
            5'd6:    return 7'b10_0_1_1_0_1;
            5'd7:    return 7'b10_1_1_1_0_0;
            default: return 7'b00_0_0_0_0_0;
        endcase
    endfunction

    function automatic logic [15:0] instr(input logic [4:0] op, input logic [10:0] arg);
        return {op, arg};
    endfunction

    task automatic do_reset();
        i_start = 1'b0;
        @(negedge clk);
        #2 i_reset = 1'b1;
        @(negedge clk);
        check("rst_addr",   64'(o_prog_addr),   64'd0);
        check("rst_strobe", 64'(strobes()),     64'd0);
        check("rst_cycles", 64'(o_cycle_count), 64'd0);
        check("rst_halt",   64'(o_halt),        64'd0);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    // Instruction-level model: each instruction is one FETCH then one EXEC cycle.
    task automatic run_program(input int max_instr, input bit patch0,
                               output int cnt, output int pc);
        logic [15:0] ins;
        bit          done;
        pc   = 0;
        cnt  = 0;
        done = 1'b0;
        i_start = 1'b1;
        for (int n = 0; n < max_instr && !done; n++) begin
            @(negedge clk);
            check("fetch_addr", 64'(o_prog_addr), 64'(pc));
            check("fetch_strb", 64'(strobes()), 64'd0);
            check("fetch_cnt",  64'(o_cycle_count), 64'(cnt));
            check("fetch_halt", 64'(o_halt), 64'd0);
            cnt++;
            @(negedge clk);
            ins = mem[pc];
            check("exec_strb", 64'(strobes()), 64'({ref_ctrl(ins[15:11]), ins[10:0]}));
            check("exec_cnt",  64'(o_cycle_count), 64'(cnt));
            cnt++;
            if (ins[15:11] == 5'd0) done = 1'b1;
            else pc = (pc + 1) % MEM_DEPTH;
            if (patch0 && n == 0) mem[0] = instr(5'd0, 11'd0);
        end
        check("halt_reached", 64'(done), 64'd1);
        @(negedge clk);
        check("halt_flag",   64'(o_halt), 64'd1);
        check("halt_cnt",    64'(o_cycle_count), 64'(cnt));
        check("halt_addr",   64'(o_prog_addr), 64'(pc));
        check("halt_strb",   64'(strobes()), 64'd0);
    endtask

    initial begin
        int cnt;
        int pc;
        int len;
        i_reset = 1'b1;
        i_start = 1'b0;
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = '0;

        // Directed program: LDI 5, ADDI 3, STO 7, HLT.
        do_reset();
        mem[0] = instr(5'd3, 11'd5);
        mem[1] = instr(5'd5, 11'd3);
        mem[2] = instr(5'd1, 11'd7);
        mem[3] = instr(5'd0, 11'd0);
        run_program(10, 1'b0, cnt, pc);
        check("dir_cycles8", 64'(o_cycle_count), 64'd8);
        check("dir_pc3",     64'(o_prog_addr),   64'd3);

        // i_start toggling while halted must change nothing.
        for (int k = 0; k < 10; k++) begin
            i_start = k[0];
            @(negedge clk);
            check("halt_stay",    64'(o_halt), 64'd1);
            check("halt_frozen",  64'(o_cycle_count), 64'd8);
            check("halt_quiet",   64'({o_prog_addr, strobes()}), 64'({11'd3, 18'd0}));
        end

        // Idle with i_start low.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_state", 64'({o_prog_addr, strobes(), o_halt}), 64'd0);
            check("idle_cnt",   64'(o_cycle_count), 64'd0);
        end

        // Undefined opcode acts as NOP.
        do_reset();
        mem[0] = instr(5'd31, 11'h7ff);
        mem[1] = instr(5'd0, 11'd0);
        run_program(5, 1'b0, cnt, pc);
        check("nop_cycles4", 64'(o_cycle_count), 64'd4);
        check("nop_pc1",     64'(o_prog_addr),   64'd1);

        // PC wrap: 2048 NOPs, then address 0 becomes HLT after its first use.
        do_reset();
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = instr(5'd8, 11'(a));
        run_program(MEM_DEPTH + 2, 1'b1, cnt, pc);
        check("wrap_cycles", 64'(o_cycle_count), 64'd4098);
        check("wrap_pc0",    64'(o_prog_addr),   64'd0);

        // Async reset during ADD's EXEC cycle.
        do_reset();
        mem[0] = instr(5'd4, 11'd9);
        i_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("add_exec", 64'(strobes()), 64'({7'b10_0_1_0_0_1, 11'd9}));
        #1 i_reset = 1'b1;
        #1;
        check("rst_mid_strb", 64'({o_rd_ram, o_enb_acc, strobes()}), 64'd0);
        check("rst_mid_pc",   64'(o_prog_addr), 64'd0);
        check("rst_mid_cnt",  64'(o_cycle_count), 64'd0);
        i_start = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_idle", 64'({o_prog_addr, strobes(), o_cycle_count}), 64'd0);
        end
        mem[0] = instr(5'd0, 11'd0);
        run_program(3, 1'b0, cnt, pc);
        check("rst_mid_rerun", 64'(o_cycle_count), 64'd2);

        // Randomized programs with a random idle gap before start.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            len = int'($urandom_range(1, 40));
            for (int a = 0; a < len; a++)
                mem[a] = instr(5'($urandom_range(1, 31)), 11'($urandom));
            mem[len] = instr(5'd0, 11'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
                @(negedge clk);
                check("rnd_idle", 64'({o_prog_addr, strobes(), o_cycle_count}), 64'd0);
            end
            run_program(len + 2, 1'b0, cnt, pc);
            check("rnd_cycles", 64'(o_cycle_count), 64'(2 * (len + 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
